// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the comparator-sharing arbiter.
// The signed/unsigned compare mode is chosen by CMP_SHARE_SIGNED_EN in cmp_magnitude.
package cmp_share_pkg;

  localparam int CMP_ID_MAX_W = 16;
  localparam logic [CMP_ID_MAX_W-1:0] CMP_ID_ONE = 16'd1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [CMP_ID_MAX_W-1:0] id;
    logic                    lt;
    logic                    eq;
    logic                    gt;
  } rsp_t;

  // Round-robin successor of idx among num requesters, wrapping to zero.
  function automatic logic [CMP_ID_MAX_W-1:0] rr_next_ptr(
    input logic [CMP_ID_MAX_W-1:0] idx,
    input logic [CMP_ID_MAX_W-1:0] num
  );
    if (idx >= (num - CMP_ID_ONE)) begin
      return '0;
    end else begin
      return idx + CMP_ID_ONE;
    end
  endfunction

endpackage

// File: rtl/cmp_magnitude.sv
// Single N-bit magnitude comparator; two's complement when CMP_SHARE_SIGNED_EN is defined,
// unsigned otherwise.
module cmp_magnitude #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

`ifdef CMP_SHARE_SIGNED_EN
  assign lt = ($signed(a) < $signed(b));
  assign gt = ($signed(a) > $signed(b));
`else
  assign lt = (a < b);
  assign gt = (a > b);
`endif
  assign eq = (a == b);

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin grant selection: first asserted request at or after ptr, with wrap.
// The pointer register is owned by the parent.
module cmp_rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  int   sum_v;
  int   idx_v;
  logic found_s;

  // Scan requesters starting at ptr; the first valid one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    sum_v   = 0;
    idx_v   = 0;
    if (en) begin
      for (int k = 0; k < R; k++) begin
        sum_v = int'(ptr) + k;
        idx_v = (sum_v >= R) ? (sum_v - R) : sum_v;
        if (!found_s && req[IDW'(idx_v)]) begin
          found_s             = 1'b1;
          gnt[IDW'(idx_v)]    = 1'b1;
          gnt_idx             = IDW'(idx_v);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one magnitude comparator among R requesters through a round-robin arbiter
// and a one-entry result register. CMP_SHARE_SIGNED_EN selects two's-complement compare.
module cmp_share_arbiter
  import cmp_share_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [R-1:0]        req_valid,
  input  logic [R-1:0][N-1:0] req_a,
  input  logic [R-1:0][N-1:0] req_b,
  output logic [R-1:0]        req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_lt,
  output logic                rsp_eq,
  output logic                rsp_gt
);

  rsp_state_e     state_r;
  rsp_state_e     state_next_s;
  rsp_t           rsp_r;
  rsp_t           rsp_next_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] ptr_next_s;
  logic [R-1:0]   grant_onehot_s;
  logic [IDW-1:0] grant_idx_s;
  logic           grant_v_s;
  logic           slot_free_s;
  logic           arb_en_s;
  logic [N-1:0]   op_a_s;
  logic [N-1:0]   op_b_s;
  logic           cmp_lt_s;
  logic           cmp_eq_s;
  logic           cmp_gt_s;
  logic           unused_id_s;

  assign slot_free_s = (state_r == EMPTY) || rsp_ready;
  // Nothing is accepted while in reset, so a same-cycle grant cannot be lost silently.
  assign arb_en_s    = rst_n && slot_free_s;
  assign grant_v_s   = |grant_onehot_s;
  assign req_ready   = grant_onehot_s;

  cmp_rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .en      (arb_en_s),
    .gnt     (grant_onehot_s),
    .gnt_idx (grant_idx_s)
  );

  assign op_a_s = req_a[grant_idx_s];
  assign op_b_s = req_b[grant_idx_s];

  cmp_magnitude #(.N(N)) u_cmp (
    .a  (op_a_s),
    .b  (op_b_s),
    .lt (cmp_lt_s),
    .eq (cmp_eq_s),
    .gt (cmp_gt_s)
  );

  // Next result contents and next pointer for a grant this cycle.
  always_comb begin
    rsp_next_s.id = CMP_ID_MAX_W'(grant_idx_s);
    rsp_next_s.lt = cmp_lt_s;
    rsp_next_s.eq = cmp_eq_s;
    rsp_next_s.gt = cmp_gt_s;
    ptr_next_s    = IDW'(rr_next_ptr(CMP_ID_MAX_W'(grant_idx_s), CMP_ID_MAX_W'(R)));
  end

  // Result-register occupancy: refill on grant, drain when consumed without refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (grant_v_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (grant_v_s) begin
          state_next_s = FULL;
        end else if (rsp_ready) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State, result and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      rsp_r   <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if (grant_v_s) begin
        rsp_r <= rsp_next_s;
        ptr_r <= ptr_next_s;
      end
    end
  end

  assign unused_id_s = ^rsp_r.id;
  assign rsp_valid   = (state_r == FULL);
  assign rsp_id      = rsp_r.id[IDW-1:0];
  assign rsp_lt      = rsp_r.lt;
  assign rsp_eq      = rsp_r.eq;
  assign rsp_gt      = rsp_r.gt;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: a stimulus process predicts grants and results,
// a monitor process pops and compares results as the DUT hands them off.
module tb_cmp_share_arbiter;

  localparam int N   = 8;
  localparam int R   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           lt;
    logic           eq;
    logic           gt;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [R-1:0]        req_valid;
  logic [R-1:0][N-1:0] req_a;
  logic [R-1:0][N-1:0] req_b;
  logic [R-1:0]        req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_lt;
  logic                rsp_eq;
  logic                rsp_gt;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int   m_ptr  = 0;
  logic m_full = 1'b0;

  logic [R-1:0][N-1:0] ta;
  logic [R-1:0][N-1:0] tb;

  cmp_share_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference compare from plain integer arithmetic.
  function automatic exp_t model_cmp(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   va;
    int   vb;
    va = int'(a);
    vb = int'(b);
`ifdef CMP_SHARE_SIGNED_EN
    if (va >= (1 << (N - 1))) va -= (1 << N);
    if (vb >= (1 << (N - 1))) vb -= (1 << N);
`endif
    e.id = IDW'(id);
    e.lt = (va < vb);
    e.eq = (va == vb);
    e.gt = (va > vb);
    return e;
  endfunction

  // One cycle: drive at negedge, predict and check handshake, update the model.
  task automatic drive(input logic rstn, input logic [R-1:0] v,
                       input logic [R-1:0][N-1:0] a, input logic [R-1:0][N-1:0] b,
                       input logic rdy);
    logic [R-1:0] exp_ready;
    int           g;
    @(negedge clk);
    rst_n     = rstn;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    g         = -1;
    exp_ready = '0;
    if (rstn && (!m_full || rdy)) begin
      for (int k = 0; k < R; k++) begin
        if (g < 0 && v[(m_ptr + k) % R]) g = (m_ptr + k) % R;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (!rstn) begin
      q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
    end else if (g >= 0) begin
      q.push_back(model_cmp(g, a[g], b[g]));
      m_ptr  = (g + 1) % R;
      m_full = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: compare the held result whenever it is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_data", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'(e));
          chk("rsp_onehot", 32'(rsp_lt) + 32'(rsp_eq) + 32'(rsp_gt), 32'd1);
        end
      end
    end
  end

  initial begin
    logic [IDW+2:0] snap;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    @(negedge clk);

    // Reset held with every requester pending.
    for (int c = 0; c < 3; c++) drive(1'b0, '1, ta, tb, 1'b1);

    // Fairness from ptr=0, one result per cycle.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < R; i++) begin
        ta[i] = N'($urandom);
        tb[i] = N'($urandom);
      end
      drive(1'b1, '1, ta, tb, 1'b1);
      chk("fair_order", 32'(req_ready), 32'd1 << (c % R));
    end
    drive(1'b1, '0, ta, tb, 1'b1);

    // Basic single requester: lt, then eq.
    ta = '0; tb = '0;
    ta[2] = 8'h10; tb[2] = 8'h20;
    drive(1'b1, 4'b0100, ta, tb, 1'b1);
    drive(1'b1, 4'b0000, ta, tb, 1'b0);
    chk("basic_lt", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'b1_10_100);
    ta[2] = 8'h55; tb[2] = 8'h55;
    drive(1'b1, 4'b0100, ta, tb, 1'b1);
    drive(1'b1, 4'b0000, ta, tb, 1'b0);
    chk("basic_eq", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'b1_10_010);

    // Backpressure: held result stays put and no grants for 5 cycles.
    snap = {rsp_id, rsp_lt, rsp_eq, rsp_gt};
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, '1, ta, tb, 1'b0);
      chk("bp_stable", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'(snap));
    end
    drive(1'b1, '1, ta, tb, 1'b1);
    chk("bp_release_grant", 32'(req_ready), 32'b1000);
    drive(1'b1, '0, ta, tb, 1'b1);

    // Signedness of 0x80 vs 0x01.
    ta[0] = 8'h80; tb[0] = 8'h01;
    drive(1'b1, 4'b0001, ta, tb, 1'b1);
    drive(1'b1, 4'b0000, ta, tb, 1'b0);
`ifdef CMP_SHARE_SIGNED_EN
    chk("signed_cmp", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'b100);
`else
    chk("unsigned_cmp", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'b001);
`endif

    // Reset mid-flight while FULL and stalled.
    drive(1'b0, '1, ta, tb, 1'b0);
    drive(1'b1, '1, ta, tb, 1'b1);
    chk("post_reset_ptr0", 32'(req_ready), 32'b0001);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < R; i++) begin
        ta[i] = N'($urandom);
        tb[i] = ($urandom_range(0, 3) == 0) ? ta[i] : N'($urandom);
      end
      drive(($urandom_range(0, 99) != 0), R'($urandom), ta, tb, ($urandom_range(0, 3) != 0));
    end

    // Drain outstanding results with a bounded budget.
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      drive(1'b1, '0, ta, tb, 1'b1);
      #2;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
